// File: rtl/branch_predict_table.sv
// Branch predictor: table of saturating counters indexed by PC (bimodal) or
// PC XOR global history (gshare), updated when a branch resolves in EX.
`ifndef B_type
`define B_type 7'b1100011
`endif

module branch_predict_table #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 6,
  parameter int MODE    = 1,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [31:0]      IF_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_index,
  input  logic [6:0]       EX_op,
  input  logic [IDX_W-1:0] EX_index,
  input  logic             EX_pred_taken,
  input  logic             actual_taken,
  output logic             mispredict,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] cnt_tab [ENTRIES];
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] ghr_ext;
  logic             upd;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{IF_pc[31:IDX_W+2], IF_pc[1:0]};

  assign upd        = (EX_op == `B_type) && !stall;
  assign mispredict = upd && (EX_pred_taken != actual_taken);

  // Zero-extend history to the index width; a cast avoids a zero-width replicate
  assign ghr_ext    = IDX_W'(ghr);
  assign pred_index = (MODE == 1) ? (IF_pc[IDX_W+1:2] ^ ghr_ext) : IF_pc[IDX_W+1:2];

  // Reads the registered entry, so a same-cycle update is not forwarded
  assign pred_taken = cnt_tab[pred_index][CNT_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_tab[i] <= CNT_INIT;
    end else if (upd) begin
      if (actual_taken) begin
        if (cnt_tab[EX_index] != CNT_MAX) cnt_tab[EX_index] <= cnt_tab[EX_index] + 1'b1;
      end else begin
        if (cnt_tab[EX_index] != '0) cnt_tab[EX_index] <= cnt_tab[EX_index] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ghr <= '0;
    else if (upd && (MODE == 1))
      ghr <= GHR_W'({ghr, actual_taken});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
      if (mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table: a bimodal and a gshare instance
// share stimulus; expected values are queued at drive time and popped on sampling.
`ifndef B_type
`define B_type 7'b1100011
`endif

module tb_branch_predict_table;

  localparam int IDX_W = 6;
  localparam logic [6:0] BOP = `B_type;

  logic             clk;
  logic             rst;
  logic             stall;
  logic [31:0]      IF_pc;
  logic [6:0]       EX_op;
  logic [IDX_W-1:0] EX_index;
  logic             EX_pred_taken;
  logic             actual_taken;

  logic             pt0, pt1, mp0, mp1;
  logic [IDX_W-1:0] pi0, pi1;
  logic [31:0]      bc0, bc1, mc0, mc1;

  int passes = 0;
  int total  = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  branch_predict_table #(.ENTRIES(64), .CNT_W(2), .GHR_W(6), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .IF_pc(IF_pc),
    .pred_taken(pt0), .pred_index(pi0), .EX_op(EX_op), .EX_index(EX_index),
    .EX_pred_taken(EX_pred_taken), .actual_taken(actual_taken),
    .mispredict(mp0), .branch_cnt(bc0), .mispred_cnt(mc0)
  );

  branch_predict_table #(.ENTRIES(64), .CNT_W(2), .GHR_W(6), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .IF_pc(IF_pc),
    .pred_taken(pt1), .pred_index(pi1), .EX_op(EX_op), .EX_index(EX_index),
    .EX_pred_taken(EX_pred_taken), .actual_taken(actual_taken),
    .mispredict(mp1), .branch_cnt(bc1), .mispred_cnt(mc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL scoreboard_empty: got %0d, required an expectation", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) passes++;
    else $error("FAIL %s: got %0d required %0d", t, obs, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; IF_pc = 32'h40; EX_op = 7'd0;
    EX_index = '0; EX_pred_taken = 1'b0; actual_taken = 1'b0;
    #2;
    push("rst_pred_taken", 0); cmp(pt0);
    push("rst_mispredict", 0); cmp(mp0);
    push("rst_branch_cnt", 0); cmp(bc0);
    push("rst_mispred_cnt", 0); cmp(mc1);
    @(negedge clk); rst = 1'b0; #1;
    push("bimodal_index_0x40", 16); cmp(pi0);
    push("post_rst_pred_taken", 0); cmp(pt0);
    push("post_rst_branch_cnt", 0); cmp(bc0);

    // Non-branch op never flags a mispredict
    EX_op = 7'd0; EX_pred_taken = 1'b1; actual_taken = 1'b0; #1;
    push("nonbranch_mispredict", 0); cmp(mp0);

    // Four taken updates at 16: 01->10->11->11
    EX_op = BOP; EX_index = 6'd16; EX_pred_taken = 1'b1; actual_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("taken_mispredict", 0);
      push("taken_pred_taken", 1);
      #1; cmp(mp0);
      tick(); cmp(pt0);
    end

    // Two not-taken updates: 11->10 (still taken), 10->01
    EX_pred_taken = 1'b1; actual_taken = 1'b0;
    push("nt1_mispredict", 1); push("nt1_pred_taken", 1);
    #1; cmp(mp0); tick(); cmp(pt0);
    push("nt2_mispredict", 1); push("nt2_pred_taken", 0);
    #1; cmp(mp0); tick(); cmp(pt0);
    EX_op = 7'd0; #1;
    push("mispred_cnt_after_nt", 2); cmp(mc0);
    push("branch_cnt_after_six", 6); cmp(bc0);

    // Stall blocks every update
    stall = 1'b1; EX_op = BOP; EX_index = 6'd16; EX_pred_taken = 1'b0; actual_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push("stall_mispredict", 0);
      #1; cmp(mp0);
      tick();
    end
    stall = 1'b0; EX_op = 7'd0; #1;
    push("stall_branch_cnt", 6); cmp(bc0);
    push("stall_mispred_cnt", 2); cmp(mc0);
    push("stall_entry16_pred", 0); cmp(pt0);

    // Same-cycle predict and update at index 5: old value this cycle, new next
    IF_pc = 32'h14; EX_op = BOP; EX_index = 6'd5; EX_pred_taken = 1'b0; actual_taken = 1'b1;
    push("bypass_index", 5); push("bypass_pred_same_cycle", 0); push("bypass_mispredict", 1);
    push("bypass_pred_next", 1);
    #1; cmp(pi0); cmp(pt0); cmp(mp0);
    tick(); EX_op = 7'd0; #1; cmp(pt0);
    IF_pc = 32'h40; #1;
    push("untouched_entry16", 0); cmp(pt0);
    IF_pc = 32'h18; #1;
    push("untouched_entry6", 0); cmp(pt0);

    // Reset asserted while an update is pending: update discarded
    IF_pc = 32'h14; EX_op = BOP; EX_index = 6'd5; actual_taken = 1'b1;
    @(negedge clk); rst = 1'b1;
    tick(); EX_op = 7'd0;
    @(negedge clk); rst = 1'b0; #1;
    push("midrst_entry5", 0); cmp(pt0);
    push("midrst_branch_cnt", 0); cmp(bc0);
    push("midrst_mispred_cnt", 0); cmp(mc0);

    // Gshare history: T,T,N -> ghr=000110, index for 0x40 = 16^6 = 22
    IF_pc = 32'h0; EX_op = BOP; EX_index = 6'd0; EX_pred_taken = 1'b1;
    actual_taken = 1'b1; tick();
    actual_taken = 1'b1; tick();
    actual_taken = 1'b0; tick();
    EX_op = 7'd0; IF_pc = 32'h40; #1;
    push("gshare_index", 22); cmp(pi1);
    push("bimodal_index_after_hist", 16); cmp(pi0);
    push("gshare_branch_cnt", 3); cmp(bc1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
